// File: rtl/parameterized_direct_mapped_cache_pkg.sv
// rtl/parameterized_direct_mapped_cache_pkg.sv - shared types and helpers for the direct-mapped cache
//
// Purpose: controller state encoding and the index-width helper used to
// split a word address into line index and tag.
package parameterized_direct_mapped_cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    FETCH = 2'd2
  } cache_state_e;

  // Index width for a given number of lines; never below 1 so the index
  // vector always has a legal width.
  function automatic int idx_width(input int words);
    return (words < 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/parameterized_direct_mapped_cache_cache_line_store.sv
// rtl/parameterized_direct_mapped_cache_cache_line_store.sv - valid/tag/data line arrays
//
// Purpose: storage for the cache lines. One synchronous write port that
// sets the valid bit, tag and data of a line; one asynchronous read port.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (valid bits only)
//   we, widx, wtag, wdata   write port
//   ridx                read index
//   rvalid, rtag, rdata combinational read of line ridx
module cache_line_store #(
  parameter int WORDS = 1024,
  parameter int IW    = 10,
  parameter int TW    = 2,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] widx,
  input  logic [TW-1:0] wtag,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] ridx,
  output logic          rvalid,
  output logic [TW-1:0] rtag,
  output logic [DW-1:0] rdata
);

  logic [WORDS-1:0] valid_q;
  logic [TW-1:0]    tag_q  [WORDS];
  logic [DW-1:0]    data_q [WORDS];

  // Only the valid bits are cleared; stale tag/data are harmless once invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wdata;
    end
  end

  assign rvalid = valid_q[ridx];
  assign rtag   = tag_q[ridx];
  assign rdata  = data_q[ridx];

endmodule

// File: rtl/parameterized_direct_mapped_cache.sv
// rtl/parameterized_direct_mapped_cache.sv - write-through direct-mapped cache controller
//
// Purpose: one-word-per-line direct-mapped cache. Reads hit from the line
// store or request a line fill (fetch/fetch_ack); writes always replace the
// line and are written through to RAM (flush/flush_ack).
// Ports:
//   clka, rsta          clock, asynchronous active-high reset
//   wea, addra, dina    CPU request; dina also carries fetched RAM data
//   fetch_ack, flush_ack RAM handshakes
//   douta               registered read data
//   flush, fetch        registered RAM requests
//   hit                 combinational hit for addra while idle
module parameterized_direct_mapped_cache
  import parameterized_direct_mapped_cache_pkg::*;
#(
  parameter int CACHE_WORDS = 1024,
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  fetch_ack,
  input  logic                  flush_ack,
  output logic [DATA_WIDTH-1:0] douta,
  output logic                  flush,
  output logic                  fetch,
  output logic                  hit
);

  localparam int IW = idx_width(CACHE_WORDS);
  localparam int TW = ADDR_WIDTH - IW;

  cache_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] douta_q, douta_d;
  logic                  flush_q, flush_d;
  logic                  fetch_q, fetch_d;

  logic [IW-1:0]         addr_idx;
  logic [TW-1:0]         addr_tag;
  logic                  line_we;
  logic                  line_valid;
  logic [TW-1:0]         line_tag;
  logic [DATA_WIDTH-1:0] line_data;

  assign addr_idx = addra[IW-1:0];
  assign addr_tag = addra[ADDR_WIDTH-1:IW];

  cache_line_store #(
    .WORDS(CACHE_WORDS),
    .IW   (IW),
    .TW   (TW),
    .DW   (DATA_WIDTH)
  ) u_store (
    .clk   (clka),
    .rst   (rsta),
    .we    (line_we),
    .widx  (addr_idx),
    .wtag  (addr_tag),
    .wdata (dina),
    .ridx  (addr_idx),
    .rvalid(line_valid),
    .rtag  (line_tag),
    .rdata (line_data)
  );

  assign hit = (state_q == IDLE) && line_valid && (line_tag == addr_tag);

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q <= IDLE;
      douta_q <= '0;
      flush_q <= 1'b0;
      fetch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      douta_q <= douta_d;
      flush_q <= flush_d;
      fetch_q <= fetch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    douta_d = douta_q;
    flush_d = flush_q;
    fetch_d = fetch_q;
    line_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wea) begin
          // Writes replace the line regardless of hit, then write through.
          line_we = 1'b1;
          douta_d = dina;
          flush_d = 1'b1;
          state_d = FLUSH;
        end else if (hit) begin
          douta_d = line_data;
          flush_d = 1'b0;
          fetch_d = 1'b0;
        end else begin
          fetch_d = 1'b1;
          state_d = FETCH;
        end
      end
      FLUSH: begin
        if (flush_ack) begin
          flush_d = 1'b0;
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (fetch_ack) begin
          line_we = 1'b1;
          douta_d = dina;
          fetch_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        flush_d = 1'b0;
        fetch_d = 1'b0;
      end
    endcase
  end

  assign douta = douta_q;
  assign flush = flush_q;
  assign fetch = fetch_q;

endmodule

// File: tb/tb_parameterized_direct_mapped_cache.sv
// tb/tb_parameterized_direct_mapped_cache.sv - directed bench for the direct-mapped cache
module tb_parameterized_direct_mapped_cache;

  logic        clka = 1'b0;
  logic        rsta = 1'b1;
  logic        wea = 1'b0;
  logic [11:0] addra = '0;
  logic [31:0] dina = '0;
  logic        fetch_ack = 1'b0;
  logic        flush_ack = 1'b0;
  logic [31:0] douta;
  logic        flush;
  logic        fetch;
  logic        hit;

  int passed = 0;
  int total  = 0;

  parameterized_direct_mapped_cache #(1024, 12, 32) dut (
    .clka     (clka),
    .rsta     (rsta),
    .wea      (wea),
    .addra    (addra),
    .dina     (dina),
    .fetch_ack(fetch_ack),
    .flush_ack(flush_ack),
    .douta    (douta),
    .flush    (flush),
    .fetch    (fetch),
    .hit      (hit)
  );

  always #5 clka = ~clka;

  typedef struct {
    bit          is_write;
    logic [11:0] addr;
    logic [31:0] data;      // write data, or fill data on a miss
    bit          exp_miss;  // reads only
    logic [31:0] exp_douta;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clka);
    @(negedge clka);
  endtask

  task automatic do_write(input string nm, input logic [11:0] a, input logic [31:0] d,
                          input logic [31:0] exp_d);
    addra = a; dina = d; wea = 1'b1;
    tick();
    wea = 1'b0;
    chk({nm, " flush raised"}, 32'(flush), 32'd1);
    chk({nm, " no fetch"}, 32'(fetch), 32'd0);
    tick();
    chk({nm, " flush held"}, 32'(flush), 32'd1);
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;
    chk({nm, " flush dropped"}, 32'(flush), 32'd0);
    chk({nm, " douta"}, douta, exp_d);
  endtask

  task automatic do_read(input string nm, input logic [11:0] a, input logic [31:0] fill,
                         input bit miss, input logic [31:0] exp_d);
    addra = a; wea = 1'b0;
    #1;
    chk({nm, " hit"}, 32'(hit), miss ? 32'd0 : 32'd1);
    tick();
    if (miss) begin
      chk({nm, " fetch raised"}, 32'(fetch), 32'd1);
      repeat (10) tick();
      chk({nm, " fetch held"}, 32'(fetch), 32'd1);
      dina = fill; fetch_ack = 1'b1;
      tick();
      fetch_ack = 1'b0; dina = 32'hDEAD_BEEF;
      chk({nm, " fetch dropped"}, 32'(fetch), 32'd0);
      chk({nm, " hit after fill"}, 32'(hit), 32'd1);
    end else begin
      chk({nm, " fetch low"}, 32'(fetch), 32'd0);
    end
    chk({nm, " douta"}, douta, exp_d);
    chk({nm, " flush low"}, 32'(flush), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 12'd0,    32'd2123000123, 1'b0, 32'd2123000123};
    vecs[1] = '{1'b0, 12'd1000, 32'd1002003009, 1'b1, 32'd1002003009};
    vecs[2] = '{1'b0, 12'd0,    32'd0,          1'b0, 32'd2123000123};
    vecs[3] = '{1'b1, 12'd1024, 32'd998,        1'b0, 32'd998};
    vecs[4] = '{1'b0, 12'd0,    32'd55,         1'b1, 32'd55};
    vecs[5] = '{1'b0, 12'd1024, 32'd77,         1'b1, 32'd77};
    vecs[6] = '{1'b0, 12'd1000, 32'd0,          1'b0, 32'd1002003009};

    // Reset state
    @(negedge clka);
    @(negedge clka);
    chk("reset douta", douta, 32'd0);
    chk("reset flush", 32'(flush), 32'd0);
    chk("reset fetch", 32'(fetch), 32'd0);
    chk("reset hit", 32'(hit), 32'd0);
    rsta = 1'b0;
    tick();
    // Address 0 missed in the cycle reset released; let that fill complete with a known word.
    if (fetch) begin
      dina = 32'd0; fetch_ack = 1'b1; tick(); fetch_ack = 1'b0;
    end

    for (int i = 0; i < 7; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      if (vecs[i].is_write) do_write(nm, vecs[i].addr, vecs[i].data, vecs[i].exp_douta);
      else do_read(nm, vecs[i].addr, vecs[i].data, vecs[i].exp_miss, vecs[i].exp_douta);
    end

    // Stray acks while idle change nothing
    addra = 12'd1000; dina = 32'd12345;
    fetch_ack = 1'b1; flush_ack = 1'b1;
    tick();
    fetch_ack = 1'b0; flush_ack = 1'b0;
    chk("idle acks flush", 32'(flush), 32'd0);
    chk("idle acks fetch", 32'(fetch), 32'd0);
    chk("idle acks douta", douta, 32'd1002003009);
    chk("idle acks hit", 32'(hit), 32'd1);

    // Write during a fetch is ignored
    addra = 12'd7; wea = 1'b0;
    tick();
    chk("fetch7 raised", 32'(fetch), 32'd1);
    wea = 1'b1; dina = 32'd4444;
    tick();
    wea = 1'b0;
    chk("wea in fetch keeps fetch", 32'(fetch), 32'd1);
    chk("wea in fetch no flush", 32'(flush), 32'd0);
    chk("wea in fetch douta", douta, 32'd1002003009);
    dina = 32'd31337; fetch_ack = 1'b1;
    tick();
    fetch_ack = 1'b0;
    chk("fetch7 douta", douta, 32'd31337);
    chk("fetch7 done", 32'(fetch), 32'd0);
    do_read("reread7", 12'd7, 32'd0, 1'b0, 32'd31337);

    // Reset in the middle of a fetch
    addra = 12'd5;
    tick();
    chk("fetch5 raised", 32'(fetch), 32'd1);
    rsta = 1'b1;
    #1;
    chk("async reset fetch", 32'(fetch), 32'd0);
    chk("async reset douta", douta, 32'd0);
    tick();
    addra = 12'd1000;
    #1;
    chk("post reset 1000 hit", 32'(hit), 32'd0);
    rsta = 1'b0;
    do_read("post reset 1000", 12'd1000, 32'd6060, 1'b1, 32'd6060);
    do_read("post reset 7", 12'd7, 32'd7070, 1'b1, 32'd7070);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/parameterized_direct_mapped_cache.md
PARAMETERIZED_DIRECT_MAPPED_CACHE -- requirements
Module: parameterized_direct_mapped_cache

Interface
REQ-001 Parameter CACHE_WORDS, default 1024: number of one-word lines; power of two, at least 2.
REQ-002 Parameter ADDR_WIDTH, default 12: width of addra; greater than log2(CACHE_WORDS).
REQ-003 Parameter DATA_WIDTH, default 32: width of dina/douta.
REQ-004 Parameter order SHALL be CACHE_WORDS, ADDR_WIDTH, DATA_WIDTH, so positional override #(1024,12,32) works.
REQ-005 Clocking: one clock; reset is asynchronous and active-high.
REQ-006 clka  in  1  sole clock, rising edge.
REQ-007 rsta  in  1  asynchronous active-high reset.
REQ-008 wea  in  1  write request from the CPU side.
REQ-009 addra  in  ADDR_WIDTH  word address; held stable by the requester until the operation completes.
REQ-010 dina  in  DATA_WIDTH  write data when wea=1; fetched RAM data while fetch_ack=1.
REQ-011 fetch_ack  in  1  RAM has placed the fetched word on dina.
REQ-012 flush_ack  in  1  RAM has accepted the written-through word.
REQ-013 douta  out  DATA_WIDTH  registered read data.
REQ-014 flush  out  1  registered; write-through to RAM pending.
REQ-015 fetch  out  1  registered; line fill from RAM pending.
REQ-016 hit  out  1  combinational; current addra hits while IDLE.

Function
REQ-017 index = addra[IW-1:0], IW = log2(CACHE_WORDS); tag = addra[ADDR_WIDTH-1:IW]. Each line holds a valid bit, a tag and a data word.
REQ-018 hit = (state==IDLE) && valid[index] && tag[index]==addra tag.
REQ-019 State machine with states IDLE, FLUSH and FETCH; all transitions occur on the rising edge of clka.
REQ-020 IDLE, wea=1: write dina into line[index], set the valid bit and the tag, set douta=dina, set flush=1, go to FLUSH. A write SHALL always replace the line, whether or not it hits.
REQ-021 IDLE, wea=0, hit: set douta=line[index] data; stay in IDLE; flush=0 and fetch=0.
REQ-022 IDLE, wea=0, miss: set fetch=1, go to FETCH; douta is unchanged.
REQ-023 FLUSH: hold flush=1 until flush_ack=1 is sampled, then set flush=0 and go to IDLE.
REQ-024 FETCH: hold fetch=1 until fetch_ack=1 is sampled. On that edge: write dina into line[index], set the valid bit and the tag, set douta=dina, set fetch=0, go to IDLE.
REQ-025 Latency: hit read data on douta 1 edge after addra is presented; fetch rises 1 edge after a miss is presented.
REQ-026 wea SHALL be ignored in FLUSH and FETCH. fetch_ack SHALL be ignored outside FETCH, and flush_ack outside FLUSH.
REQ-027 flush and fetch SHALL never be high together.
REQ-028 A write to an address with the same index but a different tag evicts the old line; no write-back is needed because the cache is write-through.

Reset
REQ-029 rsta=1 SHALL asynchronously clear all valid bits, set state=IDLE and drive flush=0, fetch=0 and douta=0.
REQ-030 Reset during FLUSH or FETCH SHALL abort the operation; the pending handshake is abandoned. Tag and data arrays are not reset.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, FLUSH, FETCH) and a clog2-based index-width helper function.
REQ-032 One sub-module, cache_line_store, SHALL hold the valid, tag and data arrays with one synchronous write port and an asynchronous read port. The FSM lives in the top module.

Verification
REQ-033 Reset, then write addr 0 = 2123000123: flush=1 from the next edge; flush_ack pulse for 1 cycle -> flush=0; douta=2123000123.
REQ-034 Read addr 1000 (miss) -> fetch=1; after 10 cycles, fetch_ack=1 with dina=1002003009 -> fetch=0, douta=1002003009, hit=1.
REQ-035 Read addr 0 -> hit=1, douta=2123000123 within 2 edges, fetch stays 0.
REQ-036 Write addr 1024 = 998 plus flush handshake -> douta=998. Then read addr 0 -> hit=0 and fetch=1 within 2 edges (tag conflict eviction).
REQ-037 Assert rsta mid-FETCH -> fetch=0 immediately. A later read of any previously cached address -> miss.
REQ-038 Pulse fetch_ack/flush_ack while IDLE, and wea during FETCH -> no state, array or output change.
